// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the IF/MEM memory port arbiter:
//   - arbiter FSM state encoding
//   - transaction owner encoding
//   - NOP instruction returned to a fetch that timed out
//   - default response timeout in cycles
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_GNT  = 2'd1,
      WAIT_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam int DEFAULT_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
// Combinational winner select between the fetch and data requesters.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on ties; otherwise MEM wins).
// Ports:
//   if_req_i      fetch request
//   mem_req_i     data request
//   last_owner_i  owner granted most recently (only used for round-robin)
//   valid_o       at least one request present
//   owner_o       selected owner (meaningful when valid_o=1)
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic   if_req_i,
   input  logic   mem_req_i,
   input  owner_e last_owner_i,
   output logic   valid_o,
   output owner_e owner_o
);

   // Winner select; on a tie the round-robin build favours whoever was not granted last.
   always_comb begin
      valid_o = if_req_i | mem_req_i;
      owner_o = OWN_MEM;
`ifdef MEM_ARB_RR_EN
      if (if_req_i && mem_req_i) begin
         owner_o = (last_owner_i == OWN_MEM) ? OWN_IF : OWN_MEM;
      end else if (if_req_i) begin
         owner_o = OWN_IF;
      end
`else
      if (if_req_i && !mem_req_i) begin
         owner_o = OWN_IF;
      end
`endif
   end

`ifndef MEM_ARB_RR_EN
   // Fixed priority ignores history.
   logic unused_last_owner;
   assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-outstanding memory port between instruction fetch (IF)
// and load/store (MEM). Each transaction runs IDLE -> WAIT_GNT -> WAIT_RESP.
// Stale fetch responses after a redirect are dropped; a response that never
// arrives is replaced by a NOP/zero return with a bus_err_o pulse.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break with last_owner).
// Ports:
//   clk_i, rst_i           clock, synchronous active-low reset
//   if_*_i / if_*_o        fetch request, grant, response, redirect flush
//   mem_*_i / mem_*_o      load/store request, grant, response
//   bus_*_o                registered request to the memory slave
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i  slave accept and response
//   busy_o                 transaction in progress
//   bus_err_o              response timeout pulse
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int INST_W      = 32,
   parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   input  logic                if_flush_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [INST_W-1:0]   if_rdata_o,
   input  logic                mem_req_i,
   input  logic                mem_we_i,
   input  logic [ADDR_W-1:0]   mem_addr_i,
   input  logic [DATA_W-1:0]   mem_wdata_i,
   input  logic [DATA_W/8-1:0] mem_wmask_i,
   output logic                mem_gnt_o,
   output logic                mem_rvalid_o,
   output logic [DATA_W-1:0]   mem_rdata_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [DATA_W-1:0]   bus_wdata_o,
   output logic [DATA_W/8-1:0] bus_wmask_o,
   input  logic                bus_gnt_i,
   input  logic                bus_rvalid_i,
   input  logic [DATA_W-1:0]   bus_rdata_i,
   output logic                busy_o,
   output logic                bus_err_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   arb_state_e          state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                drop_q, drop_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                bus_req_q, bus_req_d;
   logic                bus_we_q, bus_we_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic [DATA_W/8-1:0] bus_wmask_q, bus_wmask_d;
   logic                pick_valid;
   owner_e              pick_owner;
   owner_e              last_owner;
   logic                timeout;

`ifdef MEM_ARB_RR_EN
   owner_e last_owner_q, last_owner_d;
   assign last_owner = last_owner_q;
`else
   assign last_owner = OWN_IF;
`endif

   mem_arb_pick u_pick (
      .if_req_i     (if_req_i),
      .mem_req_i    (mem_req_i),
      .last_owner_i (last_owner),
      .valid_o      (pick_valid),
      .owner_o      (pick_owner)
   );

   // The counter starts at 0 in the first WAIT_RESP cycle, so TIMEOUT_CYC-1
   // marks the last cycle we are willing to wait.
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   // Next-state logic plus the combinational grant and response pass-through.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      drop_d       = drop_q;
      cnt_d        = cnt_q;
      bus_req_d    = bus_req_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_wmask_d  = bus_wmask_q;
`ifdef MEM_ARB_RR_EN
      last_owner_d = last_owner_q;
`endif
      if_gnt_o     = 1'b0;
      mem_gnt_o    = 1'b0;
      if_rvalid_o  = 1'b0;
      mem_rvalid_o = 1'b0;
      if_rdata_o   = '0;
      mem_rdata_o  = '0;
      bus_err_o    = 1'b0;

      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            if (pick_valid) begin
               state_d   = WAIT_GNT;
               bus_req_d = 1'b1;
               owner_d   = pick_owner;
`ifdef MEM_ARB_RR_EN
               last_owner_d = pick_owner;
`endif
               if (pick_owner == OWN_MEM) begin
                  mem_gnt_o   = 1'b1;
                  bus_we_d    = mem_we_i;
                  bus_addr_d  = mem_addr_i;
                  bus_wdata_d = mem_wdata_i;
                  bus_wmask_d = mem_wmask_i;
               end else begin
                  if_gnt_o    = 1'b1;
                  bus_we_d    = 1'b0;
                  bus_addr_d  = if_addr_i;
                  bus_wdata_d = '0;
                  bus_wmask_d = '0;
                  // A redirect in the grant cycle already makes this fetch stale.
                  drop_d      = if_flush_i;
               end
            end
         end
         WAIT_GNT: begin
            if (owner_q == OWN_IF && if_flush_i) begin
               drop_d = 1'b1;
            end
            if (bus_gnt_i) begin
               bus_req_d = 1'b0;
               cnt_d     = '0;
               state_d   = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (owner_q == OWN_IF && if_flush_i) begin
               drop_d = 1'b1;
            end
            // A real response beats a timeout landing in the same cycle.
            if (bus_rvalid_i || timeout) begin
               state_d   = IDLE;
               drop_d    = 1'b0;
               bus_err_o = ~bus_rvalid_i;
               if (owner_q == OWN_MEM) begin
                  mem_rvalid_o = 1'b1;
                  mem_rdata_o  = bus_rvalid_i ? bus_rdata_i : '0;
               end else if (!(drop_q || if_flush_i)) begin
                  if_rvalid_o = 1'b1;
                  if (!bus_rvalid_i) begin
                     if_rdata_o = NOP_INST;
                  end else if (bus_addr_q[2]) begin
                     if_rdata_o = bus_rdata_i[INST_W +: INST_W];
                  end else begin
                     if_rdata_o = bus_rdata_i[0 +: INST_W];
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Keep every combinational output quiet while reset is held.
      if (!rst_i) begin
         if_gnt_o     = 1'b0;
         mem_gnt_o    = 1'b0;
         if_rvalid_o  = 1'b0;
         mem_rvalid_o = 1'b0;
         if_rdata_o   = '0;
         mem_rdata_o  = '0;
         bus_err_o    = 1'b0;
      end
   end

   // State and bus registers; reset abandons any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         drop_q      <= 1'b0;
         cnt_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wmask_q <= '0;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= OWN_IF;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         drop_q      <= drop_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wmask_q <= bus_wmask_d;
`ifdef MEM_ARB_RR_EN
         last_owner_q <= last_owner_d;
`endif
      end
   end

   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = bus_we_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_wdata_o = bus_wdata_q;
   assign bus_wmask_o = bus_wmask_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a small timeout (4 cycles).
// Expected responses are queued when the slave response is driven and popped
// by a monitor whenever the DUT pulses if_rvalid_o or mem_rvalid_o.
// Honours MEM_ARB_RR_EN in its arbitration model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifReq, ifFlush, memReq, memWe;
   logic [63:0] ifAddr, memAddr, memWdata;
   logic [7:0]  memWmask;
   logic        ifGnt, ifRvalid, memGnt, memRvalid;
   logic [31:0] ifRdata;
   logic [63:0] memRdata;
   logic        busReq, busWe;
   logic [63:0] busAddr, busWdata;
   logic [7:0]  busWmask;
   logic        busGnt, busRvalid;
   logic [63:0] busRdata;
   logic        busy, busErr;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        isIf;
      logic [63:0] data;
   } resp_t;
   resp_t sbQueue[$];

   // Expected bus fields and owner of the transaction under way.
   logic        expIsIf;
   logic        expWe;
   logic [63:0] expAddr, expWdata;
   logic [7:0]  expMask;
   logic        benchLastIf;
   // 0: no flush, 1: flush in first WAIT_RESP cycle, 2: flush with the response
   int          flushMode;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT_CYC(TO)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .if_req_i     (ifReq),
      .if_addr_i    (ifAddr),
      .if_flush_i   (ifFlush),
      .if_gnt_o     (ifGnt),
      .if_rvalid_o  (ifRvalid),
      .if_rdata_o   (ifRdata),
      .mem_req_i    (memReq),
      .mem_we_i     (memWe),
      .mem_addr_i   (memAddr),
      .mem_wdata_i  (memWdata),
      .mem_wmask_i  (memWmask),
      .mem_gnt_o    (memGnt),
      .mem_rvalid_o (memRvalid),
      .mem_rdata_o  (memRdata),
      .bus_req_o    (busReq),
      .bus_we_o     (busWe),
      .bus_addr_o   (busAddr),
      .bus_wdata_o  (busWdata),
      .bus_wmask_o  (busWmask),
      .bus_gnt_i    (busGnt),
      .bus_rvalid_i (busRvalid),
      .bus_rdata_i  (busRdata),
      .busy_o       (busy),
      .bus_err_o    (busErr)
   );

   // Single point of comparison and failure reporting.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Response monitor: every rvalid pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      resp_t e;
      #2;
      if (ifRvalid || memRvalid) begin
         if (sbQueue.size() == 0) begin
            checkOutput("rvalid_unexpected", {62'd0, ifRvalid, memRvalid}, 64'd0);
         end else begin
            e = sbQueue.pop_front();
            checkOutput("sb_if_rvalid", {63'd0, ifRvalid}, {63'd0, e.isIf});
            checkOutput("sb_mem_rvalid", {63'd0, memRvalid}, {63'd0, ~e.isIf});
            checkOutput("sb_data", e.isIf ? {32'd0, ifRdata} : memRdata, e.data);
         end
      end
   end

   // Drive requests in an IDLE cycle and check which side is granted.
   task automatic applyStimulus(input bit reqIf, input bit reqMem, input bit we,
                                input logic [63:0] mAddr, input logic [63:0] wdata,
                                input logic [7:0] mask, input logic [63:0] iAddr);
      @(negedge clk);
      busRvalid = 1'b0;
      ifFlush   = 1'b0;
      ifReq     = reqIf;
      ifAddr    = iAddr;
      memReq    = reqMem;
      memWe     = we;
      memAddr   = mAddr;
      memWdata  = wdata;
      memWmask  = mask;
`ifdef MEM_ARB_RR_EN
      expIsIf = reqIf && (!reqMem || !benchLastIf);
`else
      expIsIf = reqIf && !reqMem;
`endif
      benchLastIf = expIsIf;
      expWe    = expIsIf ? 1'b0 : we;
      expAddr  = expIsIf ? iAddr : mAddr;
      expWdata = expIsIf ? 64'd0 : wdata;
      expMask  = expIsIf ? 8'd0 : mask;
      #1;
      checkOutput("busy_idle", {63'd0, busy}, 64'd0);
      checkOutput("if_gnt", {63'd0, ifGnt}, {63'd0, expIsIf});
      checkOutput("mem_gnt", {63'd0, memGnt}, {63'd0, ~expIsIf});
   endtask

   // Slave side of one granted transaction; ends in the response/timeout cycle.
   task automatic completeTxn(input int gntDelay, input int respDelay, input bit noResp,
                              input logic [63:0] rdata);
      int    lastK;
      resp_t e;
      @(negedge clk);
      if (expIsIf) ifReq = 1'b0;
      else         memReq = 1'b0;
      #1;
      checkOutput("bus_req_set", {63'd0, busReq}, 64'd1);
      checkOutput("busy_set", {63'd0, busy}, 64'd1);
      checkOutput("bus_we", {63'd0, busWe}, {63'd0, expWe});
      checkOutput("bus_addr", busAddr, expAddr);
      checkOutput("bus_wdata", busWdata, expWdata);
      checkOutput("bus_wmask", {56'd0, busWmask}, {56'd0, expMask});
      for (int i = 0; i < gntDelay; i++) begin
         @(negedge clk);
         #1;
         checkOutput("bus_req_held", {63'd0, busReq}, 64'd1);
         checkOutput("bus_we_held", {63'd0, busWe}, {63'd0, expWe});
         checkOutput("bus_wmask_held", {56'd0, busWmask}, {56'd0, expMask});
      end
      busGnt = 1'b1;
      lastK = noResp ? TO - 1 : respDelay;
      for (int k = 0; k <= lastK; k++) begin
         @(negedge clk);
         busGnt    = 1'b0;
         ifFlush   = ((flushMode == 1) && (k == 0)) || ((flushMode == 2) && (k == lastK));
         busRvalid = (k == lastK) && !noResp;
         busRdata  = rdata;
         if (k == lastK && !(expIsIf && flushMode != 0)) begin
            e.isIf = expIsIf;
            if (noResp)       e.data = expIsIf ? 64'h13 : 64'd0;
            else if (!expIsIf) e.data = rdata;
            else if (expAddr[2]) e.data = {32'd0, rdata[63:32]};
            else               e.data = {32'd0, rdata[31:0]};
            sbQueue.push_back(e);
         end
         #1;
         if (k == 0) checkOutput("bus_req_drop", {63'd0, busReq}, 64'd0);
         checkOutput("bus_err", {63'd0, busErr}, {63'd0, noResp && (k == lastK)});
         checkOutput("no_gnt_busy", {62'd0, ifGnt, memGnt}, 64'd0);
      end
   endtask

   initial begin
      rst = 1'b0;
      ifReq = 1'b1; memReq = 1'b1; ifFlush = 1'b0; memWe = 1'b0;
      ifAddr = '0; memAddr = '0; memWdata = '0; memWmask = '0;
      busGnt = 1'b0; busRvalid = 1'b0; busRdata = '0;
      benchLastIf = 1'b1;
      flushMode = 0;

      // Reset: requests present but everything must stay quiet.
      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_bus_req", {63'd0, busReq}, 64'd0);
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_gnt", {62'd0, ifGnt, memGnt}, 64'd0);
      checkOutput("rst_rvalid_err", {61'd0, ifRvalid, memRvalid, busErr}, 64'd0);
      checkOutput("rst_rdata", memRdata | {32'd0, ifRdata}, 64'd0);
      ifReq = 1'b0; memReq = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // IF-only fetch, upper word selected by addr[2].
      applyStimulus(1, 0, 0, 64'd0, 64'd0, 8'd0, 64'h8000_0004);
      completeTxn(0, 1, 0, 64'h1111_2222_3333_4444);

      // Tie: MEM load first, IF (held) granted only after the response.
      applyStimulus(1, 1, 0, 64'h8000_0100, 64'd0, 8'd0, 64'h8000_0000);
      completeTxn(0, 0, 0, 64'hA5A5_0000_1234_5678);
      applyStimulus(1, 0, 0, 64'd0, 64'd0, 8'd0, 64'h8000_0000);
      completeTxn(1, 0, 0, 64'hCAFE_F00D_8765_4321);

      // Store held through a slow bus_gnt; acknowledged by rvalid.
      applyStimulus(0, 1, 1, 64'h8000_0200, 64'hDEAD_BEEF, 8'h0F, 64'd0);
      completeTxn(2, 1, 0, 64'h55);

      // Flush during WAIT_RESP drops the fetch; next fetch is normal.
      flushMode = 1;
      applyStimulus(1, 0, 0, 64'd0, 64'd0, 8'd0, 64'h8000_0010);
      completeTxn(0, 2, 0, 64'h7777_8888_9999_AAAA);
      flushMode = 0;
      applyStimulus(1, 0, 0, 64'd0, 64'd0, 8'd0, 64'h8000_0014);
      completeTxn(0, 0, 0, 64'h0102_0304_0506_0708);

      // Flush coinciding with the response drops it.
      flushMode = 2;
      applyStimulus(1, 0, 0, 64'd0, 64'd0, 8'd0, 64'h8000_0018);
      completeTxn(0, 1, 0, 64'h1357_9BDF_2468_ACE0);
      // Flush while MEM owns the port has no effect.
      flushMode = 1;
      applyStimulus(0, 1, 0, 64'h8000_0300, 64'd0, 8'd0, 64'd0);
      completeTxn(0, 1, 0, 64'hFEDC_BA98_7654_3210);
      flushMode = 0;

      // Timeouts: IF gets the NOP, MEM gets zero; response on the last cycle wins.
      applyStimulus(1, 0, 0, 64'd0, 64'd0, 8'd0, 64'h8000_0020);
      completeTxn(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(0, 1, 0, 64'h8000_0400, 64'd0, 8'd0, 64'd0);
      completeTxn(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(1, 0, 0, 64'd0, 64'd0, 8'd0, 64'h8000_0024);
      completeTxn(0, TO - 1, 0, 64'h0BAD_F00D_0000_0001);

      // Repeated ties follow the arbitration model.
      for (int n = 0; n < 3; n++) begin
         applyStimulus(1, 1, 0, 64'h8000_0500 + 64'(n * 8), 64'd0, 8'd0, 64'h8000_0600);
         completeTxn(0, 0, 0, 64'h1000 + 64'(n));
      end

      // Reset during WAIT_GNT abandons the transaction.
      applyStimulus(1, 0, 0, 64'd0, 64'd0, 8'd0, 64'h8000_0700);
      @(negedge clk);
      ifReq = 1'b0; memReq = 1'b0; busRvalid = 1'b0;
      #1;
      checkOutput("pre_rst_bus_req", {63'd0, busReq}, 64'd1);
      rst = 1'b0;
      benchLastIf = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("mid_rst_bus_req", {63'd0, busReq}, 64'd0);
      checkOutput("mid_rst_busy", {63'd0, busy}, 64'd0);
      rst = 1'b1;
      applyStimulus(0, 1, 0, 64'h8000_0800, 64'd0, 8'd0, 64'd0);
      completeTxn(0, 0, 0, 64'h2222_3333_4444_5555);

      @(negedge clk);
      busRvalid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-outstanding memory port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sits between the fetch/memory pipeline stages and the unified SRAM/bus port.
- Sequences every transaction through request, grant and response.
- Drops stale fetch responses after a branch redirect.
- Bounds the wait for a response with a timeout.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, bus data width.
- INST_W, 32, instruction width.
- TIMEOUT_CYC, 255, maximum number of cycles spent in WAIT_RESP before an error return.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch redirect; the in-flight fetch response must be discarded
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  INST_W  fetched instruction
- mem_req  in  1  data request; held until mem_gnt
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_wmask  in  DATA_W/8  byte strobes
- mem_gnt  out  1  data request accepted (1-cycle pulse)
- mem_rvalid  out  1  load data or store acknowledge (1-cycle pulse)
- mem_rdata  out  DATA_W  load data
- bus_req  out  1  bus request (registered)
- bus_we  out  1  registered
- bus_addr  out  ADDR_W  registered
- bus_wdata  out  DATA_W  registered
- bus_wmask  out  DATA_W/8  registered
- bus_gnt  in  1  slave accepted the request
- bus_rvalid  in  1  response / write acknowledge
- bus_rdata  in  DATA_W  response data
- busy  out  1  state != IDLE
- bus_err  out  1  timeout pulse

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - All outputs 0; if_rdata=0, mem_rdata=0.
  - Owner, drop flag and timeout counter cleared.
  - Reset mid-transaction abandons the transaction; the bus slave is reset alongside.
- IDLE:
  - If any request is present, pick the winner. MEM has priority over IF; see the optional feature for the alternative.
  - Pulse the winner's gnt combinationally in the same cycle.
  - Latch owner, addr, we, wdata and wmask into the bus registers.
  - Next cycle: bus_req=1, state=WAIT_GNT.
  - An IF request always drives we=0 and wmask=0.
- WAIT_GNT:
  - bus_req and all fields stay stable until bus_gnt=1.
  - On bus_gnt: bus_req<=0, counter<=0, state<=WAIT_RESP.
- WAIT_RESP:
  - On bus_rvalid, pulse the owner's rvalid in the same cycle (combinational pass-through), then state<=IDLE.
  - A new arbitration happens no earlier than the following cycle, so the minimum transaction is 3 cycles (IDLE→WAIT_GNT→WAIT_RESP) plus slave latency.
  - IF data: if_rdata = addr[2] ? bus_rdata[63:32] : bus_rdata[31:0].
  - MEM data: mem_rdata = bus_rdata.
- Flush handling:
  - if_flush=1 while the owner is IF in WAIT_GNT or WAIT_RESP, or coinciding with the if_gnt cycle, sets the drop flag.
  - The transaction still completes on the bus, but if_rvalid is suppressed.
  - The drop flag clears on return to IDLE.
  - if_flush in IDLE, or while the owner is MEM, has no effect.
- Timeout:
  - The counter increments each cycle in WAIT_RESP.
  - When it reaches TIMEOUT_CYC without bus_rvalid, pulse bus_err and return to IDLE.
  - The owner still receives rvalid, with data NOP: IF gets 32'h13, MEM gets 0. A dropped IF owner stays silent.
- Simultaneous events:
  - bus_rvalid in the same cycle as the timeout: the response wins and bus_err stays 0.
  - if_flush and bus_rvalid in the same cycle: the response is dropped.
- Requests are ignored outside IDLE; gnt is never asserted outside IDLE.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. A last_owner register is updated on each grant; when both stages request, the one not granted last wins. Reset value: last_owner=IF, so MEM wins the first tie.
- Undefined: fixed MEM>IF priority and no last_owner register.

Decomposition:
- Shared define file: state encodings (IDLE/WAIT_GNT/WAIT_RESP), owner encodings (OWN_IF/OWN_MEM), NOP instruction constant 32'h13, default TIMEOUT_CYC.
- One sub-module, mem_arb_pick: combinational winner select from if_req, mem_req and last_owner, with the round-robin path under the macro.
- The FSM, registers and counter stay in the top module.

Test Plan:
- IF-only fetch, if_addr=0x8000_0004, slave rvalid 2 cycles after gnt with bus_rdata=0x1111_2222_3333_4444 → if_gnt pulses in the request cycle; if_rvalid pulses with if_rdata=0x1111_2222; busy falls the cycle after.
- Same-cycle if_req and mem_req (load, mem_addr=0x8000_0100) → mem_gnt first, if_gnt no earlier than the cycle after mem_rvalid. With MEM_ARB_RR_EN and a repeated tie → grants alternate MEM, IF, MEM.
- Store, mem_wmask=0x0F, mem_wdata=0xDEAD_BEEF → bus_we=1 and bus_wmask=0x0F held until bus_gnt; mem_rvalid on the ack.
- IF fetch with if_flush asserted in WAIT_RESP → bus completes, if_rvalid never asserts, next IF request is granted normally.
- TIMEOUT_CYC=4, slave never responds to an IF fetch → bus_err pulses in the 4th WAIT_RESP cycle; if_rvalid with if_rdata=0x0000_0013; state returns to IDLE.
- rst=0 asserted in WAIT_GNT → at the next edge bus_req=0, busy=0; first request after release is granted from IDLE.
